// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the memory BIST sequencer.
// Each element is described by its address direction, op count and op order.
package mbist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } elem_e;

    typedef enum logic [1:0] {
        OP_W0 = 2'd0,
        OP_W1 = 2'd1,
        OP_R0 = 2'd2,
        OP_R1 = 2'd3
    } op_e;

    // 1 when the element walks addresses from N-1 down to 0
    function automatic logic elem_down(input elem_e e);
        case (e)
            M3, M4, M5: elem_down = 1'b1;
            default:    elem_down = 1'b0;
        endcase
    endfunction

    // Index of the final op of an element (single-op elements end at 0)
    function automatic logic elem_last_op(input elem_e e);
        case (e)
            M0, M5:  elem_last_op = 1'b0;
            default: elem_last_op = 1'b1;
        endcase
    endfunction

    function automatic op_e elem_op(input elem_e e, input logic idx);
        case (e)
            M0:      elem_op = OP_W0;
            M1, M3:  elem_op = idx ? OP_W1 : OP_R0;
            M2, M4:  elem_op = idx ? OP_W0 : OP_R1;
            M5:      elem_op = OP_R0;
            default: elem_op = OP_W0;
        endcase
    endfunction

    function automatic logic op_is_write(input op_e op);
        op_is_write = (op == OP_W0) || (op == OP_W1);
    endfunction

    // Background bit replicated across the word: 1 for w1/r1
    function automatic logic op_bg(input op_e op);
        op_bg = (op == OP_W1) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter; `last` flags the final address of the
// current walk direction so the controller can wrap into the next element.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    input  logic                  dir_down,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] addr_r;

    // Counter: load takes priority so an element boundary starts at the right end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= ADDR_ZERO;
        end else if (load) begin
            addr_r <= load_down ? ADDR_MAX : ADDR_ZERO;
        end else if (step) begin
            addr_r <= dir_down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end
    end

    assign addr = addr_r;
    assign last = dir_down ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);

endmodule

// File: rtl/mbist_controller.sv
// March C- BIST sequencer: owns the memory port while running, issues one op
// per cycle, checks reads one cycle later and records the first failing address.
module mbist_controller
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  NbarT,
    output logic [ADDR_WIDTH-1:0] bist_addr,
    output logic [DATA_WIDTH-1:0] bist_wdata,
    output logic                  bist_we,
    output logic                  bist_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                state_r;
    elem_e                 elem_r;
    logic                  op_idx_r;
    logic                  ptr_end_r;
    logic                  nbart_r;
    logic                  we_r;
    logic                  re_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  done_r;
    logic                  fail_r;
    logic [ADDR_WIDTH-1:0] fail_addr_r;
    logic                  chk_valid_r;
    logic [DATA_WIDTH-1:0] chk_exp_r;
    logic [ADDR_WIDTH-1:0] chk_addr_r;

    logic                  issue_s;
    logic                  op_last_s;
    logic                  step_s;
    logic                  load_s;
    logic                  load_down_s;
    logic                  dir_down_s;
    logic                  ag_last_s;
    logic [ADDR_WIDTH-1:0] ag_addr_s;
    op_e                   op_s;
    elem_e                 next_elem_s;

    mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_down (load_down_s),
        .step      (step_s),
        .dir_down  (dir_down_s),
        .addr      (ag_addr_s),
        .last      (ag_last_s)
    );

    // Op pointer control: the pointer always names the next op to present
    always_comb begin
        issue_s = 1'b0;
        case (state_r)
            IDLE, DONE: issue_s = start;
            RUN:        issue_s = !ptr_end_r;
            default:    issue_s = 1'b0;
        endcase
        op_s        = elem_op(elem_r, op_idx_r);
        next_elem_s = elem_e'(elem_r + 3'd1);
        dir_down_s  = elem_down(elem_r);
        op_last_s   = (op_idx_r == elem_last_op(elem_r));
        step_s      = issue_s && op_last_s && !ag_last_s;
        load_s      = (issue_s && op_last_s && ag_last_s && (elem_r != M5))
                      || (state_r == FLUSH);
        load_down_s = (state_r == FLUSH) ? 1'b0 : elem_down(next_elem_s);
    end

    // Sequencer FSM, registered op outputs and delayed read check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            elem_r      <= M0;
            op_idx_r    <= 1'b0;
            ptr_end_r   <= 1'b0;
            nbart_r     <= 1'b0;
            we_r        <= 1'b0;
            re_r        <= 1'b0;
            addr_r      <= ADDR_ZERO;
            wdata_r     <= DATA_ZERO;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_addr_r <= ADDR_ZERO;
            chk_valid_r <= 1'b0;
            chk_exp_r   <= DATA_ZERO;
            chk_addr_r  <= ADDR_ZERO;
        end else begin
            // Read data arrives one cycle after the strobe, so stage the expectation
            chk_valid_r <= re_r;
            chk_exp_r   <= wdata_r;
            chk_addr_r  <= addr_r;
            if (chk_valid_r && (mem_rdata != chk_exp_r)) begin
                fail_r <= 1'b1;
                if (!fail_r) begin
                    fail_addr_r <= chk_addr_r;
                end
            end

            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r     <= RUN;
                        nbart_r     <= 1'b1;
                        done_r      <= 1'b0;
                        fail_r      <= 1'b0;
                        fail_addr_r <= ADDR_ZERO;
                    end
                end
                RUN: begin
                    if (ptr_end_r) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_r   <= DONE;
                    nbart_r   <= 1'b0;
                    done_r    <= 1'b1;
                    elem_r    <= M0;
                    op_idx_r  <= 1'b0;
                    ptr_end_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    nbart_r <= 1'b0;
                end
            endcase

            if (issue_s) begin
                we_r    <= op_is_write(op_s);
                re_r    <= !op_is_write(op_s);
                addr_r  <= ag_addr_s;
                wdata_r <= {DATA_WIDTH{op_bg(op_s)}};
                if (!op_last_s) begin
                    op_idx_r <= 1'b1;
                end else begin
                    op_idx_r <= 1'b0;
                    if (ag_last_s) begin
                        if (elem_r == M5) begin
                            ptr_end_r <= 1'b1;
                        end else begin
                            elem_r <= next_elem_s;
                        end
                    end
                end
            end else begin
                we_r    <= 1'b0;
                re_r    <= 1'b0;
                addr_r  <= ADDR_ZERO;
                wdata_r <= DATA_ZERO;
            end
        end
    end

    assign NbarT      = nbart_r;
    assign bist_addr  = addr_r;
    assign bist_wdata = wdata_r;
    assign bist_we    = we_r;
    assign bist_re    = re_r;
    assign done       = done_r;
    assign fail       = fail_r;
    assign fail_addr  = fail_addr_r;

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: behavioural RAM with stuck-at bit masks and a
// March C- reference model that predicts every op and the first mismatch.
module tb_mbist_controller;

    localparam int AW   = 2;
    localparam int DW   = 10;
    localparam int N    = 4;
    localparam int NOPS = 10 * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          nbart;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_wdata;
    logic          bist_we;
    logic          bist_re;
    logic [DW-1:0] mem_rdata;
    logic          done;
    logic          fail;
    logic [AW-1:0] fail_addr;

    mbist_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .NbarT      (nbart),
        .bist_addr  (bist_addr),
        .bist_wdata (bist_wdata),
        .bist_we    (bist_we),
        .bist_re    (bist_re),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr)
    );

    always #5 clk = ~clk;

    // Memory under test; read data is garbage except the cycle after a read strobe
    logic [DW-1:0] ram [N];
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];

    always @(posedge clk) begin
        if (bist_we) ram[bist_addr] <= bist_wdata;
        if (bist_re) mem_rdata <= (ram[bist_addr] & ~sa0[bist_addr]) | sa1[bist_addr];
        else         mem_rdata <= DW'($urandom);
    end

    // Expected op stream built from the March C- element table
    logic          exp_we   [NOPS];
    logic [AW-1:0] exp_addr [NOPS];
    logic [DW-1:0] exp_data [NOPS];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic build_ops();
        // op codes: 0=w0 1=w1 2=r0 3=r1
        int  ops_tbl  [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
        int  nops_tbl [6]    = '{1, 2, 2, 2, 2, 1};
        bit  down_tbl [6]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int  k = 0;
        for (int e = 0; e < 6; e++) begin
            for (int s = 0; s < N; s++) begin
                for (int j = 0; j < nops_tbl[e]; j++) begin
                    int a;
                    a = down_tbl[e] ? (N - 1 - s) : s;
                    exp_we[k]   = (ops_tbl[e][j] < 2);
                    exp_addr[k] = AW'(a);
                    exp_data[k] = (ops_tbl[e][j] % 2 == 1) ? {DW{1'b1}} : {DW{1'b0}};
                    k++;
                end
            end
        end
    endtask

    // Replay the op stream on a model memory and find the first faulty read
    task automatic predict(output int first, output int faddr);
        logic [DW-1:0] mm [N];
        first = -1;
        faddr = 0;
        for (int i = 0; i < NOPS; i++) begin
            int a;
            a = int'(exp_addr[i]);
            if (exp_we[i]) begin
                mm[a] = exp_data[i];
            end else if ((((mm[a] & ~sa0[a]) | sa1[a]) !== exp_data[i]) && (first < 0)) begin
                first = i;
                faddr = a;
            end
        end
    endtask

    task automatic clear_faults();
        for (int a = 0; a < N; a++) begin
            sa0[a] = {DW{1'b0}};
            sa1[a] = {DW{1'b0}};
        end
    endtask

    task automatic check_quiet(input string tag, input logic exp_done, input logic exp_fail,
                               input logic [AW-1:0] exp_faddr);
        check({tag, ".nbart"}, 0, 32'(nbart), 32'(1'b0));
        check({tag, ".we"},    0, 32'(bist_we), 32'(1'b0));
        check({tag, ".re"},    0, 32'(bist_re), 32'(1'b0));
        check({tag, ".addr"},  0, 32'(bist_addr), 32'(0));
        check({tag, ".wdata"}, 0, 32'(bist_wdata), 32'(0));
        check({tag, ".done"},  0, 32'(done), 32'(exp_done));
        check({tag, ".fail"},  0, 32'(fail), 32'(exp_fail));
        check({tag, ".faddr"}, 0, 32'(fail_addr), 32'(exp_faddr));
    endtask

    // One complete test from the start pulse through the first DONE cycle
    task automatic run_test(input string tag, input bit hold_start);
        int first, faddr;
        bit exp_fail;
        predict(first, faddr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        for (int c = 1; c <= NOPS + 2; c++) begin
            @(negedge clk);
            check({tag, ".nbart"}, c, 32'(nbart), 32'(c <= NOPS + 1));
            if (c <= NOPS) begin
                check({tag, ".we"},   c, 32'(bist_we), 32'(exp_we[c-1]));
                check({tag, ".re"},   c, 32'(bist_re), 32'(!exp_we[c-1]));
                check({tag, ".addr"}, c, 32'(bist_addr), 32'(exp_addr[c-1]));
                if (exp_we[c-1]) check({tag, ".wdata"}, c, 32'(bist_wdata), 32'(exp_data[c-1]));
            end else begin
                check({tag, ".we"},    c, 32'(bist_we), 32'(1'b0));
                check({tag, ".re"},    c, 32'(bist_re), 32'(1'b0));
                check({tag, ".addr"},  c, 32'(bist_addr), 32'(0));
                check({tag, ".wdata"}, c, 32'(bist_wdata), 32'(0));
            end
            exp_fail = (first >= 0) && (c >= first + 3);
            check({tag, ".fail"},  c, 32'(fail), 32'(exp_fail));
            check({tag, ".faddr"}, c, 32'(fail_addr), exp_fail ? 32'(faddr) : 32'(0));
            check({tag, ".done"},  c, 32'(done), 32'(c == NOPS + 2));
        end
        start = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] one_hot;
        build_ops();
        clear_faults();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset", 1'b0, 1'b0, {AW{1'b0}});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("idle", 1'b0, 1'b0, {AW{1'b0}});

        run_test("clean", 1'b0);

        sa0[2][3] = 1'b1;
        run_test("sa0_a2b3", 1'b0);

        clear_faults();
        sa1[1][0] = 1'b1;
        sa1[3][5] = 1'b1;
        run_test("sa1_a1a3", 1'b0);

        clear_faults();
        run_test("restart_clean", 1'b0);
        run_test("hold_start", 1'b1);

        // Reset while op 20 is on the port
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (21) @(negedge clk);
        check("midrst.op20_addr", 21, 32'(bist_addr), 32'(exp_addr[20]));
        check("midrst.nbart_pre", 21, 32'(nbart), 32'(1'b1));
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midrst", 1'b0, 1'b0, {AW{1'b0}});
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("midrst_idle", 1'b0, 1'b0, {AW{1'b0}});
        run_test("after_rst", 1'b0);

        // Randomised fault sets, idle gaps and start styles
        for (int t = 0; t < 8; t++) begin
            clear_faults();
            for (int f = 0; f < int'($urandom_range(0, 3)); f++) begin
                int a, b;
                a = int'($urandom_range(0, N - 1));
                b = int'($urandom_range(0, DW - 1));
                one_hot = {DW{1'b0}};
                one_hot[b] = 1'b1;
                if ($urandom_range(0, 1) == 1) sa1[a] = sa1[a] | one_hot;
                else                           sa0[a] = sa0[a] | one_hot;
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_test($sformatf("rand%0d", t), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mbist_controller.md
# mbist_controller

March-test sequencer for the memory built-in self-test path. On `start` it takes the memory port away from the functional logic by driving the `NbarT` select of the normal/BIST input multiplexers. It then runs a fixed March C- algorithm over every address and compares each read against the expected background. It reports `done`, a sticky `fail`, and the first failing address.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: memory address width. N = 2**ADDR_WIDTH words.
- `DATA_WIDTH`, default 10: memory word width. Matches the `WIDTH` of the BIST multiplexers.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: request a test; sampled only in IDLE or DONE.
- `NbarT`  out  1: mux select; 0 = normal path, 1 = BIST path.
- `bist_addr`  out  ADDR_WIDTH: address to the BIST side of the address mux.
- `bist_wdata`  out  DATA_WIDTH: write data, all-0 or all-1 background.
- `bist_we`  out  1: write strobe, one cycle per write op.
- `bist_re`  out  1: read strobe, one cycle per read op.
- `mem_rdata`  in  DATA_WIDTH: memory read data, valid exactly 1 cycle after `bist_re`.
- `done`  out  1: test complete; held until the next accepted `start`.
- `fail`  out  1: sticky mismatch flag; cleared on an accepted `start`.
- `fail_addr`  out  ADDR_WIDTH: address of the first mismatch; holds its value until the next accepted `start`.

## Operation
- States:
  - IDLE: start=1 goes to RUN.
  - RUN: after the last op, goes to FLUSH.
  - FLUSH: goes to DONE after 1 cycle.
  - DONE: start=1 goes to RUN.
- `NbarT` = 1 only in RUN and FLUSH. In all other states it is 0.
- March elements, in order. ⇑ means address 0→N-1; ⇓ means N-1→0.
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇓(r0)
- Ops within an element run address by address. All ops of one address complete before the next address.
- Total ops: 10N. One op per cycle, with no idle cycles between ops or between elements.
- Backgrounds: w0/r0 use {DATA_WIDTH{1'b0}}; w1/r1 use {DATA_WIDTH{1'b1}}.
- Read check:
  - On each read, the expected value and the address are registered.
  - The next cycle compares `mem_rdata` against the registered expected value.
  - On a mismatch, `fail` is set on the following edge.
  - `fail_addr` is loaded only if `fail` was 0.
- The test always runs to completion; a mismatch does not abort it.
- `start` during RUN/FLUSH is ignored.
- An accepted `start` clears `done`, `fail` and `fail_addr`.
- Outside RUN, `bist_we`, `bist_re`, `bist_addr` and `bist_wdata` are 0.
- Reset values: state IDLE; `NbarT`, `bist_we`, `bist_re`, `done`, `fail` are 0; `bist_addr`, `bist_wdata`, `fail_addr` are 0.
- Reset asserted mid-test: all outputs return to reset values on the next edge. `NbarT` drops immediately at that edge, and the partial result is discarded.

## Timing
- `start` sampled at edge k: op 0 is presented in cycle k+1, and `NbarT` is 1 from cycle k+1.
- Op i occupies cycle k+1+i, for i = 0..10N-1.
- The read for op i has `mem_rdata` valid in cycle k+2+i. A mismatch is visible on `fail` from cycle k+3+i.
- FLUSH is cycle k+10N+1; it compares the final M5 read.
- `done` is 1 and `NbarT` is 0 from cycle k+10N+2.
- The address counter wraps at the end of each element and the element index advances on that same edge. Example: M2's last address N-1 is followed immediately by M3's first address N-1.

## Structure
- `mbist_pkg`:
  - state enum {IDLE, RUN, FLUSH, DONE}
  - march-element enum M0..M5
  - op enum {OP_W0, OP_W1, OP_R0, OP_R1}
  - per-element constants: direction, op count, op sequence
- Sub-module `mbist_addr_gen`:
  - loadable up/down address counter with an `last` flag
  - instantiated once; the controller FSM owns the element index and the op index.

## Test plan
Bench: ADDR_WIDTH=2 (N=4), DATA_WIDTH=10, behavioural RAM with a 1-cycle read. Cycle numbers are relative to `start` sampled at edge k.
- Fault-free RAM, pulse `start`: `NbarT`=1 during k+1..k+41; 40 ops; `done`=1 at k+42; `fail`=0.
- Bit 3 of address 2 stuck-at-0: first mismatch on op 16 (M2 r1 at address 2); `fail`=1 from k+19; `fail_addr`=2; `done` at k+42.
- Stuck-at-1 faults at addresses 1 and 3: `fail_addr`=1 (first mismatch wins); `fail` stays 1 to the end.
- `start` held high throughout RUN: no restart; `done` at k+42.
- From DONE with `fail`=1, pulse `start`: `fail` and `done` clear at k+1; a clean run ends with `fail`=0.
- `rst_n`=0 at op 20: next edge gives `NbarT`=0, all strobes 0, state IDLE. A new `start` then runs the full 40 ops.
